sample_resizer: RTL and testbench
=================================

SAMPLE_RESIZER -- requirements
Module: sample_resizer

Interface
REQ-001 The block SHALL have parameter IN_W, default 24: input sample width in bits, signed two's complement.
REQ-002 The block SHALL have parameter OUT_W, default 16: output sample width in bits, signed; OUT_W != IN_W.
REQ-003 The block SHALL have parameter CHANNELS, default 2: number of channels packed per frame, channel 0 in the LSBs.
REQ-004 The block SHALL have parameter DEPTH, default 4: output FIFO depth in frames, a power of 2 and at least 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port enn, input, 1 bit: enable; when low, accepted frames are converted to all-zero samples.
REQ-008 The block SHALL have port round_en, input, 1 bit: for narrowing, 1 selects round-half-up with saturation, 0 selects truncation.
REQ-009 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, CHANNELS*IN_W): the input frame handshake.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, CHANNELS*OUT_W): the output frame handshake.
REQ-011 The block SHALL have port sat_count, output, 16 bits: a saturating count of clipped samples.

Function
REQ-012 A frame SHALL be accepted only on a cycle with in_valid=1 and in_ready=1, with in_ready = !full.
REQ-013 A frame SHALL be popped only on a cycle with out_valid=1 and out_ready=1, with out_valid = !empty.
REQ-014 For narrowing (OUT_W<IN_W), with truncation selected, each channel SHALL be an arithmetic right shift by S=IN_W-OUT_W.
REQ-015 For narrowing with round_en=1, each channel SHALL be (x + 2^(S-1)) >>> S computed at IN_W+1 bits, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-016 For widening (OUT_W>IN_W), each channel SHALL be x << (OUT_W-IN_W) with zero fill, and round_en SHALL be ignored.
REQ-017 Conversion SHALL occur at accept time; an accepted frame SHALL appear on out_data with out_valid=1 exactly one cycle later if the FIFO was empty.
REQ-018 out_data SHALL always present the FIFO head entry, and it SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 Frames SHALL be emitted in FIFO order, with no drop and no duplication.
REQ-020 When full, a simultaneous pop SHALL NOT enable a push in the same cycle (no pass-through); in_ready SHALL rise on the cycle after the pop.
REQ-021 When empty, an input frame SHALL NOT bypass the FIFO; the path has no combinational in-to-out route.
REQ-022 On a cycle with both a push and a pop while neither full nor empty, occupancy SHALL be unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an occupancy counter of log2(DEPTH)+1 bits.
REQ-024 sat_count SHALL increment by the number of channels clamped in each accepted frame, and SHALL hold at 0xFFFF.
REQ-025 A frame accepted while enn=0 SHALL store zeros and SHALL NOT increment sat_count.
REQ-026 round_en and enn SHALL be sampled per accepted frame; changing them mid-stream SHALL NOT affect frames already stored.

Reset
REQ-027 On a rising clk edge with reset=0, the FIFO SHALL be flushed, pointers and occupancy set to 0, and sat_count set to 0.
REQ-028 During reset, out_valid SHALL be 0, in_ready SHALL be 0, and out_data SHALL be 0.
REQ-029 in_ready SHALL go to 1 on the first cycle after reset=1 is sampled.
REQ-030 A reset asserted mid-stream SHALL discard all stored frames, with no partial output.

Structure
REQ-031 A shared package SHALL hold the saturation min/max constant functions, the SAT_CNT_W=16 constant and the rounding-mode enum {TRUNC, ROUND_SAT}.
REQ-032 A single sub-module, sample_fifo (parametrised width and depth, synchronous active-low reset), SHALL implement the storage; conversion is per-channel generate logic in the top.

Verification (IN_W=24, OUT_W=16, CHANNELS=2, DEPTH=4)
REQ-033 Truncate, in_data={0xFFFF80,0x1234C0}, round_en=0 -> out_data={0xFFFF,0x1234} one cycle later, sat_count=0.
REQ-034 Round, the same frame with round_en=1 -> out_data={0x0000,0x1235}.
REQ-035 Saturate, {0x800000,0x7FFFF0} with round_en=1 -> {0x8000,0x7FFF}, sat_count=1.
REQ-036 Full/backpressure, out_ready=0 and 5 valid frames offered -> 4 accepted and in_ready=0 after the 4th; then out_ready=1 -> 4 frames out in order; the 5th is accepted the cycle after the first pop.
REQ-037 enn=0 with a frame {0x7FFFFF,0x123456} -> out_data=0x00000000, sat_count unchanged.
REQ-038 Reset with 3 frames stored -> out_valid=0 the next cycle, occupancy 0, sat_count=0, in_ready=1 once reset is released.

Source files
------------

// File: rtl/sample_resizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_resizer_pkg
// Description : Shared constants, rounding-mode enum and saturation-limit
//               helpers for the sample resizer block.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_resizer_pkg;

    // Width of the clipped-sample counter.
    localparam int SAT_CNT_W = 16;

    // Narrowing mode selected per accepted frame.
    typedef enum logic {
        TRUNC     = 1'b0,
        ROUND_SAT = 1'b1
    } round_mode_t;

    // Largest value representable in a signed field of width w.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of width w.
    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_resizer_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_resizer_if
// Description : Input and output frame handshakes of the sample resizer.
//               master = frame source / sink side, slave = resizer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_resizer_if #(
    parameter int IN_W     = 24,
    parameter int OUT_W    = 16,
    parameter int CHANNELS = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*IN_W-1:0]  in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS*OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous FIFO with occupancy counter, registered storage,
//               head entry always visible on o_rdata. Reset is synchronous
//               and active-low and clears the storage as well.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Guard the requests so a careless caller cannot overflow or underflow.
    assign o_full  = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write and flush; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + c_aw'(1);
        end
    end

    // Read pointer and occupancy tracking; push+pop together leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/sample_resizer.sv
`default_nettype none
// ============================================================================
// Module      : sample_resizer
// Description : Converts packed multi-channel signed samples from IN_W to
//               OUT_W bits (truncate, round-half-up with saturation, or
//               zero-fill widen) at accept time, and buffers the converted
//               frames in an output FIFO. Counts clipped samples.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_resizer
    import sample_resizer_pkg::*;
#(
    parameter int IN_W     = 24,
    parameter int OUT_W    = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 enn,
    input  wire logic                 round_en,
    sample_resizer_if.slave           bus,
    output logic      [SAT_CNT_W-1:0] sat_count
);
    localparam int c_fw = CHANNELS * OUT_W;

    logic                     r_active;
    logic [SAT_CNT_W-1:0]     r_sat_count;
    logic [SAT_CNT_W:0]       w_sat_next;
    logic [c_fw-1:0]          w_conv_data;
    logic [CHANNELS-1:0]      w_clip;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [$clog2(DEPTH):0]   w_count;
    round_mode_t              w_mode;

    assign w_mode = round_mode_t'(round_en);

    // Per-channel conversion; clip flags only ever come from the rounding path.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [IN_W-1:0]  w_x;
        logic [OUT_W-1:0] w_res;
        logic             w_clp;

        assign w_x = bus.in_data[c*IN_W +: IN_W];

        if (OUT_W < IN_W) begin : g_narrow
            localparam int c_s = IN_W - OUT_W;
            localparam logic [IN_W:0] c_half = (IN_W+1)'(1) << (c_s - 1);
            localparam logic signed [OUT_W:0] c_max = (OUT_W+1)'(sat_max(OUT_W));
            localparam logic signed [OUT_W:0] c_min = (OUT_W+1)'(sat_min(OUT_W));

            logic [IN_W:0]         w_sum;
            logic signed [OUT_W:0] w_sh;

            // One guard bit keeps the half-LSB add from wrapping before the clamp.
            assign w_sum = {w_x[IN_W-1], w_x} + c_half;
            assign w_sh  = $signed(w_sum[IN_W:c_s]);

            // Select truncation or rounded-and-clamped result for this channel.
            always_comb begin
                w_res = w_x[IN_W-1:c_s];
                w_clp = 1'b0;
                if (w_mode == ROUND_SAT) begin
                    if (w_sh > c_max) begin
                        w_res = c_max[OUT_W-1:0];
                        w_clp = 1'b1;
                    end else if (w_sh < c_min) begin
                        w_res = c_min[OUT_W-1:0];
                        w_clp = 1'b1;
                    end else begin
                        w_res = w_sh[OUT_W-1:0];
                    end
                end
            end
        end else begin : g_widen
            assign w_res = {w_x, {(OUT_W-IN_W){1'b0}}};
            assign w_clp = 1'b0;
        end

        assign w_conv_data[c*OUT_W +: OUT_W] = enn ? w_res : '0;
        assign w_clip[c] = enn & w_clp;
    end

    assign bus.in_ready  = r_active & ~w_full;
    assign bus.out_valid = ~w_empty;
    assign w_push        = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;
    assign sat_count     = r_sat_count;

    sample_fifo #(
        .WIDTH (c_fw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_conv_data),
        .o_rdata (bus.out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Input side is held off until the cycle after reset is released.
    always_ff @(posedge clk) begin
        r_active <= reset;
    end

    // Candidate clip total for this frame, one extra bit to detect overflow.
    always_comb begin
        w_sat_next = {1'b0, r_sat_count};
        for (int c = 0; c < CHANNELS; c++) begin
            w_sat_next = w_sat_next + (SAT_CNT_W+1)'(w_clip[c]);
        end
    end

    // Saturating clip counter, advanced only by accepted frames.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sat_count <= '0;
        end else if (w_push) begin
            r_sat_count <= w_sat_next[SAT_CNT_W] ? '1 : w_sat_next[SAT_CNT_W-1:0];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sample_resizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_resizer
// Description : Directed self-checking bench for sample_resizer with
//               IN_W=24, OUT_W=16, CHANNELS=2, DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_resizer;
    localparam int IN_W     = 24;
    localparam int OUT_W    = 16;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enn;
    logic        round_en;
    logic [15:0] sat_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    sample_resizer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CHANNELS)) bus ();

    sample_resizer #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enn       (enn),
        .round_en  (round_en),
        .bus       (bus.slave),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [47:0] d, input logic rnd, input logic en);
        bus.in_data  = d;
        round_en     = rnd;
        enn          = en;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"}, 64'(bus.out_data), 64'(exp));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [47:0] fin(input int i);
        return {24'((i + 1) * 256), 24'(32'h012300 + i * 256)};
    endfunction

    function automatic logic [31:0] fexp(input int i);
        return {16'(i + 1), 16'(32'h0123 + i)};
    endfunction

    initial begin
        reset         = 1'b0;
        enn           = 1'b1;
        round_en      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // Truncate, round, saturate
        push_frame(48'hFFFF80_1234C0, 1'b0, 1'b1);
        check("trunc_sat", 64'(sat_count), 64'd0);
        pop_check("trunc", 32'hFFFF_1234);
        check("trunc_empty", 64'(bus.out_valid), 64'd0);
        push_frame(48'hFFFF80_1234C0, 1'b1, 1'b1);
        pop_check("round", 32'h0000_1235);
        push_frame(48'h800000_7FFFF0, 1'b1, 1'b1);
        check("sat_cnt1", 64'(sat_count), 64'd1);
        pop_check("sat", 32'h8000_7FFF);

        // Disabled frame: zeros, no clip count even though it would clip
        push_frame(48'h7FFFFF_123456, 1'b1, 1'b0);
        pop_check("enn0", 32'h0000_0000);
        check("enn0_sat", 64'(sat_count), 64'd1);

        // Mode sampled per accepted frame
        push_frame(48'hFFFF80_1234C0, 1'b1, 1'b1);
        push_frame(48'hFFFF80_1234C0, 1'b0, 1'b1);
        pop_check("mode_a", 32'h0000_1235);
        pop_check("mode_b", 32'hFFFF_1234);

        // Full / backpressure
        round_en = 1'b0;
        enn      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data  = fin(i);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_data = fin(4);
        check("full_ready", 64'(bus.in_ready), 64'd0);
        check("full_count", 64'(dut.u_fifo.o_count), 64'd4);
        check("full_head", 64'(bus.out_data), 64'(fexp(0)));
        @(posedge clk); #1;
        check("full_hold_ready", 64'(bus.in_ready), 64'd0);
        check("full_hold_data", 64'(bus.out_data), 64'(fexp(0)));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("pop1_ready", 64'(bus.in_ready), 64'd1);
        check("pop1_count", 64'(dut.u_fifo.o_count), 64'd3);
        check("pop1_data", 64'(bus.out_data), 64'(fexp(1)));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("pushpop_count", 64'(dut.u_fifo.o_count), 64'd3);
        check("order_2", 64'(bus.out_data), 64'(fexp(2)));
        for (int i = 3; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("order_%0d", i), 64'(bus.out_data), 64'(fexp(i)));
        end
        @(posedge clk); #1;
        check("drain_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b0;

        // Reset with frames stored
        push_frame(48'h800000_7FFFF0, 1'b1, 1'b1);
        push_frame(48'hFFFF80_1234C0, 1'b0, 1'b1);
        push_frame(48'hFFFF80_1234C0, 1'b1, 1'b1);
        check("pre_rst_count", 64'(dut.u_fifo.o_count), 64'd3);
        check("pre_rst_sat", 64'(sat_count), 64'd2);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_count", 64'(dut.u_fifo.o_count), 64'd0);
        check("mid_rst_sat", 64'(sat_count), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_data", 64'(bus.out_data), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);

        // Clip counter saturates at 0xFFFF (two clips per frame)
        bus.in_data   = 48'h7FFFF0_7FFFF0;
        round_en      = 1'b1;
        enn           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (33000) @(posedge clk);
        #1;
        check("sat_hold", 64'(sat_count), 64'hFFFF);
        check("sat_stream_data", 64'(bus.out_data), 64'h7FFF_7FFF);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
